// File: rtl/decode_uop_sequencer.sv
// decode_uop_sequencer
//
// Purpose:
//   Walks a fetch bundle that may contain complex (multi-micro-op)
//   instructions and hands the decoder slots up to FETCH_WIDTH
//   (source index, step) pairs per cycle, in program order. Fetch is held
//   through o_stall until the whole bundle has been consumed.
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_valid    per-slot instruction valid from align
//   i_complex  per-slot complex flag from the simple decoders
//   i_uop_cnt  per-slot micro-op count minus 1, slot k at [k*STEP_W +: STEP_W]
//   i_stall    downstream stall
//   i_flush    pipeline flush (wins over i_stall)
//   o_sel      per-output-slot source instruction index
//   o_step     per-output-slot micro-op step
//   o_valid    per-output-slot valid
//   o_stall    hold the fetch bundle
//
// Cursor state:
//   state                     | meaning
//   --------------------------+-------------------------------------------
//   (0, 0)                    | idle / start of a fresh bundle
//   (idx, 0), idx > 0         | instructions before idx already consumed
//   (idx, step), step > 0     | complex instruction idx resumes at step
//
// FETCH_WIDTH and MAX_UOPS must both be at least 2.
module decode_uop_sequencer #(
  parameter int FETCH_WIDTH = 2,
  parameter int MAX_UOPS    = 4,
  parameter int IDX_W       = $clog2(FETCH_WIDTH),
  parameter int STEP_W      = $clog2(MAX_UOPS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [FETCH_WIDTH-1:0]        i_valid,
  input  logic [FETCH_WIDTH-1:0]        i_complex,
  input  logic [FETCH_WIDTH*STEP_W-1:0] i_uop_cnt,
  input  logic                          i_stall,
  input  logic                          i_flush,
  output logic [FETCH_WIDTH*IDX_W-1:0]  o_sel,
  output logic [FETCH_WIDTH*STEP_W-1:0] o_step,
  output logic [FETCH_WIDTH-1:0]        o_valid,
  output logic                          o_stall
);

  // One extra bit so a position can point one past the last slot.
  localparam int LEN_W = IDX_W + 1;

  logic [IDX_W-1:0]  cursor_idx;
  logic [STEP_W-1:0] cursor_step;
  logic [IDX_W-1:0]  nxt_idx;
  logic [STEP_W-1:0] nxt_step;

  // Micro-op count minus 1 per slot; simple instructions count as one.
  logic [STEP_W-1:0] cnt_a [FETCH_WIDTH];

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_cnt
    assign cnt_a[g] = i_complex[g] ? i_uop_cnt[g*STEP_W +: STEP_W] : '0;
  end

  // Effective bundle length: index of the first invalid slot. Scanning from
  // the top down leaves the lowest hole as the final answer.
  logic [LEN_W-1:0] bundle_len;

  always_comb begin
    bundle_len = LEN_W'(FETCH_WIDTH);
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (!i_valid[k]) bundle_len = LEN_W'(k);
    end
  end

  // Fill walk from the cursor. walk_mid marks that the current complex
  // instruction started earlier (this cycle or a previous one), so it may
  // continue past output slot 0; a fresh complex instruction may not.
  logic [LEN_W-1:0]  walk_idx;
  logic [STEP_W-1:0] walk_step;
  logic              walk_stop;
  logic              walk_mid;
  logic [IDX_W-1:0]  walk_src;

  logic [IDX_W-1:0]       fill_sel  [FETCH_WIDTH];
  logic [STEP_W-1:0]      fill_step [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] fill_val;
  logic                   fill_done;
  logic [LEN_W-1:0]       end_idx;
  logic [STEP_W-1:0]      end_step;

  always_comb begin
    walk_idx  = {1'b0, cursor_idx};
    walk_step = cursor_step;
    walk_stop = 1'b0;
    walk_mid  = 1'b0;
    walk_src  = '0;
    fill_val  = '0;
    for (int o = 0; o < FETCH_WIDTH; o++) begin
      fill_sel[o]  = '0;
      fill_step[o] = '0;
    end

    for (int o = 0; o < FETCH_WIDTH; o++) begin
      walk_src = walk_idx[IDX_W-1:0];
      if (walk_stop || (walk_idx >= bundle_len)) begin
        walk_stop = 1'b1;
      end else if (!i_complex[walk_src]) begin
        fill_val[o]  = 1'b1;
        fill_sel[o]  = walk_src;
        fill_step[o] = '0;
        walk_idx     = walk_idx + LEN_W'(1);
        walk_step    = '0;
      end else if (!walk_mid && (o != 0)) begin
        walk_stop = 1'b1;
      end else begin
        fill_val[o]  = 1'b1;
        fill_sel[o]  = walk_src;
        fill_step[o] = walk_step;
        // >= rather than == so a stale step beyond cnt still retires the
        // instruction instead of wrapping.
        if (walk_step >= cnt_a[walk_src]) begin
          walk_idx  = walk_idx + LEN_W'(1);
          walk_step = '0;
          walk_mid  = 1'b0;
          walk_stop = 1'b1;
        end else begin
          walk_step = walk_step + STEP_W'(1);
          walk_mid  = 1'b1;
        end
      end
    end

    end_idx   = walk_idx;
    end_step  = walk_step;
    // Also covers a stale cursor at or beyond the bundle end.
    fill_done = (walk_idx >= bundle_len);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cursor_idx  <= '0;
      cursor_step <= '0;
    end else begin
      cursor_idx  <= nxt_idx;
      cursor_step <= nxt_step;
    end
  end

  // Next-state logic.
  always_comb begin
    nxt_idx  = cursor_idx;
    nxt_step = cursor_step;
    if (i_flush) begin
      nxt_idx  = '0;
      nxt_step = '0;
    end else if (!i_stall) begin
      if (fill_done) begin
        nxt_idx  = '0;
        nxt_step = '0;
      end else begin
        nxt_idx  = end_idx[IDX_W-1:0];
        nxt_step = end_step;
      end
    end
  end

  // Output logic. Slot outputs are blanked during reset and flush.
  logic out_en;

  always_comb begin
    out_en  = i_rst_n & ~i_flush;
    o_sel   = '0;
    o_step  = '0;
    o_valid = '0;
    for (int o = 0; o < FETCH_WIDTH; o++) begin
      if (out_en && fill_val[o]) begin
        o_valid[o]                 = 1'b1;
        o_sel[o*IDX_W +: IDX_W]    = fill_sel[o];
        o_step[o*STEP_W +: STEP_W] = fill_step[o];
      end
    end
    o_stall = i_flush ? 1'b0 : (i_stall | ~fill_done);
  end

endmodule
